// File: rtl/tile_attr_memory_pkg.sv
// Shared definitions for the tile attribute store: default map geometry and
// the CPU/fill FSM state encodings.
package tile_attr_memory_pkg;

    localparam int TILE_DATA_W = 4;
    localparam int TILE_DEPTH  = 2048;

    typedef enum logic [1:0] {
        C_IDLE,
        C_RD,
        C_ACK
    } cpu_state_t;

    typedef enum logic [1:0] {
        F_IDLE,
        F_RUN,
        F_DONE
    } fill_state_t;

endpackage

// File: rtl/tile_attr_memory_fill_engine.sv
// Bulk fill engine: writes one value over a wrapping address range, one entry
// per cycle, and requests the memory write port while running.
module tile_mem_fill_engine
    import tile_attr_memory_pkg::*;
#(
    parameter int DATA_W = TILE_DATA_W,
    parameter int DEPTH  = TILE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fill_state_t       state_q, state_d;
    logic [ADDR_W:0]   remain_q;
    logic [ADDR_W:0]   count_clamped;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] value_q;

    assign count_clamped = (fill_count > DEPTH_C) ? DEPTH_C : fill_count;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE:  if (fill_start) state_d = (fill_count == '0) ? F_DONE : F_RUN;
            F_RUN:   if (remain_q == (ADDR_W+1)'(1)) state_d = F_DONE;
            F_DONE:  state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= F_IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers need no reset: they are loaded before they are used.
    always_ff @(posedge clk) begin
        if (state_q == F_IDLE && fill_start) begin
            addr_q   <= fill_base;
            remain_q <= count_clamped;
            value_q  <= fill_value;
        end else if (state_q == F_RUN) begin
            addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
            remain_q <= remain_q - 1'b1;
        end
    end

    assign fill_busy = (state_q == F_RUN);
    assign fill_done = (state_q == F_DONE);
    assign wr_en     = fill_busy;
    assign wr_addr   = addr_q;
    assign wr_data   = value_q;

endmodule

// File: rtl/tile_attr_memory.sv
// Tile attribute store: simple-dual-port array shared by video fetch (read
// priority), a handshaked CPU port, and the bulk fill engine (write priority).
module tile_attr_memory
    import tile_attr_memory_pkg::*;
#(
    parameter int DATA_W = TILE_DATA_W,
    parameter int DEPTH  = TILE_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_ren,
    input  logic [ADDR_W-1:0] vid_raddr,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_valid,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done
);

    logic [DATA_W-1:0] mem [DEPTH];

    cpu_state_t        cpu_q, cpu_d;
    logic              cpu_in_range, cpu_wr_issue, cpu_rd_issue;
    logic [DATA_W-1:0] cpu_port_q;
    logic              fill_wr_en;
    logic [ADDR_W-1:0] fill_wr_addr;
    logic [DATA_W-1:0] fill_wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] wr_data;

    tile_mem_fill_engine #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_fill (
        .clk       (clk),
        .reset     (reset),
        .fill_start(fill_start),
        .fill_base (fill_base),
        .fill_count(fill_count),
        .fill_value(fill_value),
        .fill_busy (fill_busy),
        .fill_done (fill_done),
        .wr_en     (fill_wr_en),
        .wr_addr   (fill_wr_addr),
        .wr_data   (fill_wr_data)
    );

    // A power-of-two depth makes every CPU address valid.
    if ((2 ** ADDR_W) == DEPTH) begin : g_full_range
        assign cpu_in_range = 1'b1;
    end else begin : g_part_range
        assign cpu_in_range = ({1'b0, cpu_addr} < (ADDR_W+1)'(DEPTH));
    end

    assign cpu_wr_issue = (cpu_q == C_IDLE) && cpu_valid &&  cpu_we && !fill_busy;
    assign cpu_rd_issue = (cpu_q == C_IDLE) && cpu_valid && !cpu_we && !vid_ren;

    always_comb begin
        cpu_d = cpu_q;
        case (cpu_q)
            C_IDLE: begin
                if (cpu_wr_issue)      cpu_d = C_ACK;
                else if (cpu_rd_issue) cpu_d = C_RD;
            end
            C_RD:    cpu_d = C_ACK;
            C_ACK:   cpu_d = C_IDLE;
            default: cpu_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cpu_q <= C_IDLE;
        else       cpu_q <= cpu_d;
    end

    assign cpu_ready = (cpu_q == C_ACK);

    // Write port: fill engine first, then an issued in-range CPU write.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cpu_addr;
        wr_data = cpu_wdata;
        if (fill_wr_en) begin
            wr_en   = 1'b1;
            wr_addr = fill_wr_addr;
            wr_data = fill_wr_data;
        end else if (cpu_wr_issue && cpu_in_range) begin
            wr_en = 1'b1;
        end
    end

    // NOTE: the array has no reset; contents survive reset and the block maps onto BRAM.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) mem[wr_addr] <= wr_data;
    end

    assign rd_addr = vid_ren ? vid_raddr : cpu_addr;

    // NOTE: non-blocking assignments make a same-cycle read see the pre-write contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_rdata  <= '0;
            cpu_port_q <= '0;
            cpu_rdata  <= '0;
        end else begin
            if (vid_ren)         vid_rdata  <= mem[rd_addr];
            if (cpu_rd_issue)    cpu_port_q <= cpu_in_range ? mem[rd_addr] : '0;
            if (cpu_q == C_RD)   cpu_rdata  <= cpu_port_q;
        end
    end

endmodule

// File: tb/tb_tile_attr_memory.sv
// Self-checking bench for tile_attr_memory: directed corner cases plus random
// CPU/video/fill traffic against an array model of the tile map.
module tb_tile_attr_memory;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 2048;
    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              vid_ren;
    logic [ADDR_W-1:0] vid_raddr;
    logic [DATA_W-1:0] vid_rdata;
    logic              cpu_valid, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_ready;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_count;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy, fill_done;

    logic [DATA_W-1:0] model [DEPTH];
    int checks = 0;
    int errors = 0;

    tile_attr_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .vid_ren(vid_ren), .vid_raddr(vid_raddr), .vid_rdata(vid_rdata),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU transaction with no video contention; latency counted from request.
    task automatic cpu_access(input bit we, input int addr, input logic [DATA_W-1:0] data);
        int  n;
        bit  got;
        n = 0;
        got = 0;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr[ADDR_W-1:0];
        cpu_wdata = data;
        while (!got && n < 64) begin
            tick();
            n++;
            if (cpu_ready) got = 1;
        end
        cpu_valid = 1'b0;
        check(we ? "cpu_wr_latency" : "cpu_rd_latency", n, we ? 1 : 2);
        if (we) model[addr] = data;
        else    check("cpu_rdata", cpu_rdata, model[addr]);
        tick();
        check("cpu_ready_pulse", cpu_ready, 0);
    endtask

    task automatic vid_read(input int addr);
        vid_ren   = 1'b1;
        vid_raddr = addr[ADDR_W-1:0];
        tick();
        vid_ren = 1'b0;
        check("vid_rdata", vid_rdata, model[addr]);
    endtask

    // Runs a fill to completion; optionally re-pulses fill_start mid-run, which must be ignored.
    task automatic do_fill(input int base, input int count, input logic [DATA_W-1:0] value,
                           input bit poke);
        int exp_len, busy_n, done_n, done_cyc;
        exp_len  = (count > DEPTH) ? DEPTH : count;
        busy_n   = 0;
        done_n   = 0;
        done_cyc = 0;
        fill_start = 1'b1;
        fill_base  = base[ADDR_W-1:0];
        fill_count = count[ADDR_W:0];
        fill_value = value;
        for (int c = 1; c <= exp_len + 20; c++) begin
            tick();
            fill_start = poke && (c == 2);
            fill_value = poke ? ~value : value;
            if (fill_busy) busy_n++;
            if (fill_done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (done_cyc != 0 && c >= done_cyc + 2) break;
        end
        fill_start = 1'b0;
        check("fill_busy_cycles", busy_n, exp_len);
        check("fill_done_count", done_n, 1);
        check("fill_done_cycle", done_cyc, exp_len + 1);
        for (int i = 0; i < exp_len; i++) model[(base + i) % DEPTH] = value;
    endtask

    initial begin
        int n, last_busy, ready_c, done_n;
        logic [DATA_W-1:0] v, d;

        reset = 1'b1;
        vid_ren = 1'b0; vid_raddr = '0;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_value = '0;
        repeat (3) tick();
        check("rst_vid_rdata", vid_rdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_fill_busy", fill_busy, 0);
        check("rst_fill_done", fill_done, 0);
        reset = 1'b0;
        tick();

        // Initialise the whole map; an oversized count clamps to DEPTH.
        do_fill(0, 3000, 4'($urandom), 1'b0);
        vid_read(0);
        vid_read(DEPTH - 1);

        // Video read after a CPU write, then hold while vid_ren is low.
        cpu_access(1'b1, 5, 4'hA);
        vid_read(5);
        for (int i = 0; i < 3; i++) begin
            vid_raddr = ADDR_W'($urandom);
            tick();
            check("vid_hold", vid_rdata, 4'hA);
        end

        // Same-cycle write and video read of one address returns old data.
        cpu_access(1'b1, 7, 4'hC);
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 7; cpu_wdata = 4'h3;
        vid_ren = 1'b1; vid_raddr = 7;
        tick();
        cpu_valid = 1'b0; vid_ren = 1'b0;
        check("rbw_old_data", vid_rdata, 4'hC);
        check("rbw_write_ack", cpu_ready, 1);
        model[7] = 4'h3;
        tick();
        vid_read(7);

        // CPU read stalls while video holds the read port.
        cpu_access(1'b1, 9, 4'h6);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 9;
        vid_ren = 1'b1; vid_raddr = ADDR_W'($urandom);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (n == 4) vid_ren = 1'b0;
            if (cpu_ready) break;
        end
        cpu_valid = 1'b0;
        check("rd_stall_latency", n, 6);
        check("rd_stall_data", cpu_rdata, 4'h6);
        tick();

        // Wrapping fill with an ignored restart; neighbour stays unchanged.
        cpu_access(1'b1, 2, 4'h9);
        do_fill(2046, 4, 4'h5, 1'b1);
        vid_read(2046);
        vid_read(2047);
        vid_read(0);
        vid_read(1);
        vid_read(2);

        // CPU write inside a running fill's range waits until the fill ends.
        v = 4'($urandom);
        d = ~v;
        fill_start = 1'b1; fill_base = 100; fill_count = 10; fill_value = v;
        tick();
        fill_start = 1'b0;
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 105; cpu_wdata = d;
        last_busy = 1; ready_c = 0;
        for (int c = 2; c < 60; c++) begin
            tick();
            if (fill_busy) last_busy = c;
            if (cpu_ready) begin
                ready_c = c;
                cpu_valid = 1'b0;
                break;
            end
        end
        cpu_valid = 1'b0;
        check("wr_stall_last_busy", last_busy, 10);
        check("wr_stall_ready", ready_c, last_busy + 2);
        for (int i = 0; i < 10; i++) model[100 + i] = v;
        model[105] = d;
        tick();
        vid_read(104);
        vid_read(105);

        // Fill start together with a CPU write: CPU lands first, fill overwrites.
        v = 4'($urandom);
        fill_start = 1'b1; fill_base = 200; fill_count = 3; fill_value = v;
        cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 200; cpu_wdata = ~v;
        tick();
        fill_start = 1'b0; cpu_valid = 1'b0;
        check("same_cycle_ack", cpu_ready, 1);
        done_n = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (fill_done) done_n++;
        end
        check("same_cycle_done", done_n, 1);
        for (int i = 0; i < 3; i++) model[200 + i] = v;
        vid_read(200);
        vid_read(202);

        // Zero-length fill: done next cycle and no writes.
        do_fill(300, 0, 4'($urandom), 1'b0);
        vid_read(300);

        // Reset during a 10-entry fill after three writes.
        v = 4'($urandom);
        fill_start = 1'b1; fill_base = 500; fill_count = 10; fill_value = v;
        tick();
        fill_start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_busy", fill_busy, 0);
        check("rst_mid_done", fill_done, 0);
        reset = 1'b0;
        done_n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (fill_done || fill_busy || cpu_ready) done_n++;
        end
        check("rst_mid_quiet", done_n, 0);
        for (int i = 0; i < 3; i++) model[500 + i] = v;
        for (int i = 0; i < 10; i++) vid_read(500 + i);

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            case ($urandom % 5)
                0, 1: cpu_access(1'b1, int'($urandom % DEPTH), 4'($urandom));
                2:    cpu_access(1'b0, int'($urandom % DEPTH), 4'h0);
                3:    vid_read(int'($urandom % DEPTH));
                default: do_fill(int'($urandom % DEPTH), int'($urandom_range(0, 24)),
                                 4'($urandom), 1'b0);
            endcase
        end
        for (int i = 0; i < 40; i++) vid_read(int'($urandom % DEPTH));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
